// File: rtl/prog_loader.sv
// prog_loader: parses a word stream of load frames into instruction/data
// memory writes while holding the core in reset, releases the core on START,
// then watches the decode-stage instruction for a halt encoding and raises
// a sticky halted flag once the pipeline-drain interval has elapsed.
module prog_loader #(
    parameter int ADDR_W = 16,  // must not exceed 16 (base address comes from one stream word)
    parameter int DATA_W = 16,
    parameter int DRAIN  = 10   // must be at least 1
) (
    input  logic              clk,
    input  logic              reset,       // asynchronous, active-low
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset,
    input  logic [15:0]       core_instr,
    output logic              halted,
    output logic              err
);

    localparam logic [15:0] HDR_IMEM  = 16'h0000;
    localparam logic [15:0] HDR_DMEM  = 16'h8000;
    localparam logic [15:0] HDR_START = 16'hFFFF;
    localparam logic [15:0] HALT_A    = 16'hE000;
    localparam logic [15:0] HALT_B    = 16'hE7FF;
    localparam int          DCNT_W    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_ADDR  = 3'd1,
        S_CNT   = 3'd2,
        S_DATA  = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // True for either of the two halt instruction encodings.
    function automatic logic is_halt(input logic [15:0] instr);
        return (instr == HALT_A) || (instr == HALT_B);
    endfunction

    state_t              state_q, state_d;
    logic                tgt_q, tgt_d;          // 0 = imem, 1 = dmem
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         idx_q, idx_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                imem_we_q, imem_we_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                core_reset_q, core_reset_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;
    logic                accept_s;

    // Ready is decoded from the state register alone: open in the four load states.
    always_comb begin
        case (state_q)
            S_HDR, S_ADDR, S_CNT, S_DATA: in_ready = 1'b1;
            default:                      in_ready = 1'b0;
        endcase
    end

    assign accept_s = in_valid && in_ready;

    // Frame parser, write generation, run/drain sequencing and sticky flags.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dcnt_d    = dcnt_q;
        imem_we_d = 1'b0;
        dmem_we_d = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        halted_d  = halted_q;
        err_d     = err_q;
        case (state_q)
            S_HDR: begin
                if (accept_s) begin
                    if (in_data == HDR_IMEM) begin
                        tgt_d   = 1'b0;
                        state_d = S_ADDR;
                    end else if (in_data == HDR_DMEM) begin
                        tgt_d   = 1'b1;
                        state_d = S_ADDR;
                    end else if (in_data == HDR_START) begin
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;   // bad header dropped, keep waiting for a header
                    end
                end else begin
                    state_d = S_HDR;
                end
            end
            S_ADDR: begin
                if (accept_s) begin
                    base_d  = in_data[ADDR_W-1:0];
                    state_d = S_CNT;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_CNT: begin
                if (accept_s) begin
                    cnt_d   = in_data;
                    idx_d   = 16'd0;
                    state_d = (in_data == 16'd0) ? S_HDR : S_DATA;
                end else begin
                    state_d = S_CNT;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    imem_we_d = ~tgt_q;
                    dmem_we_d = tgt_q;
                    addr_d    = base_q + idx_q[ADDR_W-1:0];   // wraps modulo 2^ADDR_W
                    wdata_d   = DATA_W'(in_data);
                    idx_d     = idx_q + 16'd1;
                    if (idx_q == (cnt_q - 16'd1)) begin
                        state_d = S_HDR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RUN: begin
                if (is_halt(core_instr)) begin
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DCNT_LAST) begin
                    halted_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    dcnt_d   = dcnt_q + DCNT_W'(1);
                end
            end
            S_DONE: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
        core_reset_d = !((state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_DONE));
    end

    // State and registered outputs; reset forces the loader back to header parsing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HDR;
            tgt_q        <= 1'b0;
            base_q       <= '0;
            cnt_q        <= 16'd0;
            idx_q        <= 16'd0;
            dcnt_q       <= '0;
            imem_we_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dcnt_q       <= dcnt_d;
            imem_we_q    <= imem_we_d;
            dmem_we_q    <= dmem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign dmem_we    = dmem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_reset = core_reset_q;
    assign halted     = halted_q;
    assign err        = err_q;

endmodule
